// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Control sequencer for a multi-cycle RV32I datapath that has one shared ALU
//   and one unified memory port. Each instruction takes several states. The
//   sequencer drives the datapath mux selects and write enables, runs a
//   req/ready handshake on the memory port and counts retired instructions.
//
// Ports
//   clk           rising-edge system clock
//   rst_n         synchronous active-low reset
//   opcode        IR[6:0]; valid from DECODE onward
//   mem_ready     memory accepted/completed the current request this cycle
//   mem_req       memory access request
//   mem_we        write access (only meaningful with mem_req)
//   i_or_d        address select: 0 = PC, 1 = ALUOut
//   ir_write      load IR from memory read data
//   pc_write      unconditional PC update
//   pc_write_cond PC update gated externally by the ALU zero flag
//   pc_src        PC source: 0 = ALU result, 1 = ALUOut
//   alu_src_a     ALU A select: 00 = PC, 01 = rs1
//   alu_src_b     ALU B select: 00 = rs2, 01 = 4, 10 = imm
//   alu_op        00 add, 01 sub/compare, 10 R-type decode, 11 I-type decode
//   reg_write     register file write enable
//   mem_to_reg    writeback select: 1 = MDR, 0 = ALUOut
//   retire        one-cycle pulse when an instruction completes
//   illegal_instr high while in TRAP
//   instret       retired-instruction count (wraps silently)
//   state_o       current state encoding, for debug
//
// Memory handshake: while the sequencer sits in FETCH, MEM_RD or MEM_WR it
// holds mem_req (and mem_we) steady and advances only in a cycle where
// mem_ready is 1. mem_ready in any other state has no effect.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_LOAD_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0] state;
  logic [3:0] state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Reset has priority, so a retire pulse in the reset cycle is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    illegal_instr = 1'b0;

    case (state)
      S_FETCH: begin
        // ALU computes PC+4 every fetch cycle; it is committed only when
        // the instruction word arrives.
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target PC+imm is precomputed into ALUOut here.
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          default:            state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_next = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = 2'b11;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_TRAP: begin
        // Sticky until reset; nothing is enabled and nothing retires.
        illegal_instr = 1'b1;
      end
      default: begin
        // Unreachable encodings recover to FETCH.
        state_next = S_FETCH;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I datapath (shared ALU, single unified memory port).
- Sequences one instruction over 3-5+ states.
- Drives the datapath muxes and enables, and runs a req/ready handshake on the memory port.
- Decodes the same opcode classes as the single-cycle decoder plus I-type ALU; keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- opcode  input  7  IR[6:0]; valid from the DECODE state onward.
- mem_ready  input  1  memory accepted/completed the current request this cycle.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write access (valid only with mem_req).
- i_or_d  output  1  address mux select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR from memory read data.
- pc_write  output  1  unconditional PC update.
- pc_write_cond  output  1  PC update gated externally by the ALU zero flag.
- pc_src  output  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = rs1 register.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = const 4, 10 = imm.
- alu_op  output  2  00 = add, 01 = sub/branch compare, 10 = R-type funct decode, 11 = I-type funct decode.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback select: 1 = MDR, 0 = ALUOut.
- retire  output  1  one-cycle pulse when an instruction completes.
- illegal_instr  output  1  high while in TRAP.
- instret  output  CNT_W  retired-instruction count.
- state_o  output  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LOAD_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, TRAP=10. Codes 11-15 are unreachable; if entered, go to FETCH.
- Reset (rst_n=0 at clk edge): state=FETCH, instret=0.
  - Outputs follow the FETCH decode: mem_req=1, i_or_d=0, mem_we=0.
  - ir_write=0, pc_write=0, retire=0, illegal_instr=0.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Drive mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0 (combinational, same cycle), next state DECODE.
  - Else stay in FETCH with no enables asserted.
- DECODE: alu_src_a=00, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other -> TRAP
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next state MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, i_or_d=1, mem_we=0. On mem_ready go to LOAD_WB; otherwise hold.
- LOAD_WB: reg_write=1, mem_to_reg=1, retire=1; next FETCH.
- MEM_WR: mem_req=1, i_or_d=1, mem_we=1. On mem_ready: retire=1 and next FETCH; otherwise hold.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10; next ALU_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=11; next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, retire=1; next FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1, retire=1; next FETCH.
- TRAP:
  - illegal_instr=1; all enables and mem_req are 0.
  - Stays in TRAP until reset. An illegal instruction never retires.
- Memory handshake:
  - mem_req and mem_we remain stable while waiting.
  - No state advances out of FETCH, MEM_RD or MEM_WR without mem_ready.
  - mem_ready while mem_req=0 is ignored.
- instret: on each retire pulse, instret <= instret+1 (registered). Wraps modulo 2^CNT_W without any flag.
- Latency with zero wait states: R/I = 4 cycles, load = 5, store = 4, branch = 3. Each cycle of mem_ready=0 during a memory state adds 1.
- Reset mid-operation: reset always wins over any transition. The pending request is abandoned and the next cycle shows the FETCH request (i_or_d=0, mem_we=0). The memory must tolerate a dropped request.

Test Plan:
- R-type: reset, opcode=0110011, mem_ready=1 -> states 0,1,6,8,0; reg_write=1 only in the ALU_WB cycle; retire at cycle 4; instret=1.
- Load with wait states: opcode=0000011, mem_ready low for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0. In MEM_RD, mem_req=1, i_or_d=1, mem_we=0 held steady; mem_to_reg=1 with reg_write in LOAD_WB; total 7 cycles.
- Store, then branch, zero wait: store takes 4 cycles with mem_we=1 only in MEM_WR; branch 1100011 takes 3 cycles with pc_write_cond=1, pc_src=1, alu_op=01 in BRANCH; instret=2.
- Illegal opcode 1111111 -> DECODE then TRAP. illegal_instr=1 persists for 20 cycles; no mem_req, reg_write or retire; instret unchanged. rst_n=0 -> returns to FETCH.
- CNT_W=4: run 16 R-type instructions -> instret steps 1..15 then 0 on the 16th retire.
- Assert rst_n=0 in the cycle after MEM_WR entry while mem_ready=0 -> next cycle state=FETCH, mem_we=0, i_or_d=0, instret=0, no retire pulse.
